fir_channel_scheduler: RTL and testbench
========================================

# fir_channel_scheduler

Time-division scheduler that shares one 4-tap shift-weighted FIR datapath (y = x + x1/2 + x2/4 + x3/8) among CH independent input channels. Round-robin arbitration picks one pending sample at a time, sequences a 4-cycle multi-cycle accumulate, keeps a private 3-deep history per channel, and presents the result with a valid/ready handshake. It sits between the per-channel sample sources and the downstream filtered-sample consumer.

## Interface
- N, 7: data MSB index; input samples are N+1 bits unsigned.
- CH, 4: number of channels, 2..8.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  CH  per-channel sample pending.
- in_data  in  CH*(N+1)  channel i sample at bits [i*(N+1)+N : i*(N+1)].
- in_ready  out  CH  one-hot (or zero) grant; transfer on in_valid[i] & in_ready[i].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  N+2  filter result, full integer sum, no truncation of the sum.
- out_ch  out  clog2(CH)  channel index of out_data.

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE: if any in_valid bit set, select channel g by round-robin starting at pointer ptr, searching ptr, ptr+1, ... modulo CH; in_ready[g]=1 combinationally that cycle, all other in_ready bits 0. On the edge: capture sample s and channel g, ptr <= (g+1) mod CH, acc <= 0, k <= 0, go to MAC. No in_valid: stay IDLE, in_ready all 0.
- in_ready is 0 in MAC and OUT.
- MAC: four cycles, k = 0..3; acc <= acc + term_k, term_0 = s, term_1 = h0[g]>>1, term_2 = h1[g]>>2, term_3 = h2[g]>>3 (logical right shift, floor). k=3 cycle: also shift channel g history h2<=h1, h1<=h0, h0<=s; go to OUT. Other channels' histories untouched.
- OUT: out_valid=1, out_data=acc, out_ch=g, held stable until out_ready=1; on that edge go to IDLE.
- Arithmetic: acc is N+2 bits; maximum 255+127+63+31=476 for N=7, never overflows.
- out_data/out_ch hold their last value when out_valid=0.
- in_valid may drop without transfer; no sample is taken unless granted.

## Timing
- Reset (async, immediate): state IDLE, ptr 0, all histories 0, acc 0, k 0, in_ready 0, out_valid 0, out_data 0, out_ch 0.
- Accept in cycle T; MAC in T+1..T+4; out_valid high from T+5.
- Minimum period per sample: 6 cycles (IDLE, 4 MAC, OUT with out_ready=1).
- Backpressure: out_ready=0 holds OUT indefinitely; no new grants.
- Simultaneous requests: only the round-robin winner is granted; losers must hold in_valid and data.
- Reset mid-MAC or mid-OUT: in-flight sample discarded, no output, all histories cleared.
- History update occurs exactly once per accepted sample, on the k=3 edge; reset during MAC before k=3 leaves histories at reset value.

## Test plan
- N=7, CH=4: channel 0 sends 8 four times, out_ready=1 -> out_data 8, 12, 14, 15, out_ch=0, out_valid first high 5 cycles after accept.
- Channel 2 sends 255 four times -> out_data 255, 382, 445, 476 (no overflow).
- After reset all four in_valid high continuously -> grant order 0,1,2,3,0; each channel's first output equals its own sample (independent histories).
- Interleave ch1=16 then ch3=100 then ch1=16 -> outputs 16 (ch1), 100 (ch3), 24 (ch1); ch3 samples do not enter ch1 history.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid, out_data, out_ch stable; in_ready stays 0 while in_valid high; one result per handshake.
- Assert rst during MAC k=2 of ch0 sample 40 (history 8) -> no output; after release ch0 sends 8 -> out_data 8.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Round-robin time-division scheduler sharing one 4-tap shift-weighted FIR
// (y = x + x1/2 + x2/4 + x3/8) across CH channels, each with a private history.
module fir_channel_scheduler #(
  parameter int unsigned N  = 7,
  parameter int unsigned CH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH-1:0]           in_valid,
  input  logic [CH*(N+1)-1:0]     in_data,
  output logic [CH-1:0]           in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N+1:0]            out_data,
  output logic [$clog2(CH)-1:0]   out_ch
);

  localparam int unsigned DW = N + 1;
  localparam int unsigned AW = N + 2;
  localparam int unsigned CW = $clog2(CH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [DW-1:0] s_q, s_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [1:0]    k_q, k_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;

  logic [DW-1:0] h0_q [CH];
  logic [DW-1:0] h1_q [CH];
  logic [DW-1:0] h2_q [CH];
  logic          hist_we;

  logic [DW-1:0] in_lane [CH];
  logic [CW-1:0] cand;
  logic          grant_found;
  logic [CW-1:0] grant_idx;
  logic [DW-1:0] grant_data;
  logic [AW-1:0] term;
  logic [AW-1:0] acc_sum;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    assign in_lane[gi] = in_data[gi*DW +: DW];
  end

  // Round-robin search starting at ptr, wrapping modulo CH
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      cand = CW'((32'(ptr_q) + i) % CH);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_data = in_lane[grant_idx];
  end

  // Shared datapath: one weighted tap per MAC cycle
  always_comb begin
    term = '0;
    case (k_q)
      2'd0:    term = AW'(s_q);
      2'd1:    term = AW'(h0_q[ch_q] >> 1);
      2'd2:    term = AW'(h1_q[ch_q] >> 2);
      default: term = AW'(h2_q[ch_q] >> 3);
    endcase
    acc_sum = acc_q + term;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    s_d         = s_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    hist_we     = 1'b0;
    in_ready    = '0;

    case (state_q)
      IDLE: begin
        if (!rst && grant_found) begin
          in_ready[grant_idx] = 1'b1;
          ch_d    = grant_idx;
          s_d     = grant_data;
          ptr_d   = (grant_idx == CW'(CH - 1)) ? '0 : grant_idx + CW'(1);
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          hist_we     = 1'b1;
          out_data_d  = acc_sum;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ch_q        <= '0;
      s_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      s_q         <= s_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // History advances once per accepted sample, on the last MAC edge only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        h0_q[i] <= '0;
        h1_q[i] <= '0;
        h2_q[i] <= '0;
      end
    end else if (hist_we) begin
      h2_q[ch_q] <= h1_q[ch_q];
      h1_q[ch_q] <= h0_q[ch_q];
      h0_q[ch_q] <= s_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid_q && !out_ready |=> out_valid_q && $stable(out_data_q) && $stable(out_ch_q));

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: cycle-level behavioural model plus
// directed scenarios with hand-computed results.
module tb_fir_channel_scheduler;

  localparam int unsigned N  = 7;
  localparam int unsigned CH = 4;
  localparam int unsigned DW = N + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     in_valid;
  logic [CH*DW-1:0]  in_data;
  logic [CH-1:0]     in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N+1:0]      out_data;
  logic [1:0]        out_ch;

  fir_channel_scheduler #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: phase 0 idle, 1..4 computing, 5 presenting a result
  int m_phase = 0, m_ptr = 0, m_g = 0, m_s = 0, m_pend = 0, m_data = 0, m_ch = 0;
  int h0[CH], h1[CH], h2[CH];
  int acc_cyc = 0;
  logic prev_ov = 1'b0;

  int log_ch[$];
  int log_dat[$];
  int grant_log[$];
  int lat_log[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [CH-1:0] exp_rdy;
    bit found;
    int c;
    cyc++;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_data = 0; m_ch = 0;
      for (int i = 0; i < CH; i++) begin h0[i] = 0; h1[i] = 0; h2[i] = 0; end
    end
    exp_rdy = '0;
    found = 1'b0;
    if (!rst && m_phase == 0) begin
      for (int i = 0; i < CH; i++) begin
        c = (m_ptr + i) % CH;
        if (!found && in_valid[c]) begin
          found = 1'b1;
          exp_rdy[c] = 1'b1;
          m_g = c;
        end
      end
    end
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("out_valid", int'(out_valid), (m_phase == 5) ? 1 : 0);
    chk("out_data", int'(out_data), m_data);
    chk("out_ch", int'(out_ch), m_ch);

    if (!rst) begin
      if ((in_valid & in_ready) != '0) begin
        for (int i = 0; i < CH; i++) if (in_ready[i]) grant_log.push_back(i);
        acc_cyc = cyc;
      end
      if (out_valid && !prev_ov) lat_log.push_back(cyc - acc_cyc);
      if (out_valid && out_ready) begin
        log_ch.push_back(int'(out_ch));
        log_dat.push_back(int'(out_data));
      end
    end
    prev_ov = out_valid;

    if (!rst) begin
      case (m_phase)
        0: if (found) begin
             m_s = int'(in_data[m_g*DW +: DW]);
             m_pend = m_s + h0[m_g] / 2 + h1[m_g] / 4 + h2[m_g] / 8;
             m_ptr = (m_g + 1) % CH;
             m_phase = 1;
           end
        1, 2, 3: m_phase++;
        4: begin
             m_phase = 5;
             m_data = m_pend;
             m_ch = m_g;
             h2[m_g] = h1[m_g];
             h1[m_g] = h0[m_g];
             h0[m_g] = m_s;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic clear_logs();
    log_ch.delete(); log_dat.delete(); grant_log.delete(); lat_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = '0;
    repeat (2) @(posedge clk);
    clear_logs();
    #1 rst = 1'b0;
  endtask

  task automatic send(input int c, input int v);
    bit done = 1'b0;
    int t = 0;
    in_data[c*DW +: DW] = DW'(v);
    in_valid[c] = 1'b1;
    while (!done && t < 100) begin
      @(negedge clk);
      if (in_ready[c]) done = 1'b1;
      t++;
    end
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
    chk("grant_seen", int'(done), 1);
  endtask

  task automatic wait_outs(input int n);
    int t = 0;
    while (log_dat.size() < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("outputs_seen", log_dat.size(), n);
  endtask

  task automatic check_outs(input string tag, input int n, input int e_ch[5], input int e_dat[5]);
    chk({tag, "_count"}, log_dat.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < log_dat.size()) begin
        chk({tag, "_data"}, log_dat[i], e_dat[i]);
        chk({tag, "_ch"}, log_ch[i], e_ch[i]);
      end
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Same sample on ch0 four times builds up its history
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      send(0, 8);
      wait_outs(i + 1);
    end
    check_outs("s1", 4, '{0, 0, 0, 0, 0}, '{8, 12, 14, 15, 0});
    chk("s1_lat_count", lat_log.size(), 4);
    for (int i = 0; i < lat_log.size(); i++) chk("s1_latency", lat_log[i], 5);

    // Full-scale samples on ch2 reach the 476 maximum
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      send(2, 255);
      wait_outs(i + 1);
    end
    check_outs("s2", 4, '{2, 2, 2, 2, 0}, '{255, 382, 445, 476, 0});

    // All channels requesting: rotation and independent histories
    do_reset();
    in_data = {8'd40, 8'd30, 8'd20, 8'd10};
    in_valid = 4'hf;
    t = 0;
    while (grant_log.size() < 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = '0;
    wait_outs(5);
    chk("s3_grant_count", grant_log.size(), 5);
    for (int i = 0; i < grant_log.size() && i < 5; i++) chk("s3_grant", grant_log[i], i % 4);
    check_outs("s3", 5, '{0, 1, 2, 3, 0}, '{10, 20, 30, 40, 15});

    // Interleaved channels do not share history
    do_reset();
    send(1, 16);  wait_outs(1);
    send(3, 100); wait_outs(2);
    send(1, 16);  wait_outs(3);
    check_outs("s4", 3, '{1, 3, 1, 0, 0}, '{16, 100, 24, 0, 0});

    // Backpressure holds the result and blocks new grants
    do_reset();
    out_ready = 1'b0;
    send(0, 50);
    in_data[1*DW +: DW] = 8'd60;
    in_valid[1] = 1'b1;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("s5_out_valid", int'(out_valid), 1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("s5_hold_ready", int'(in_ready), 0);
      chk("s5_hold_data", int'(out_data), 50);
    end
    chk("s5_no_handshake", log_dat.size(), 0);
    out_ready = 1'b1;
    t = 0;
    while (grant_log.size() < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid[1] = 1'b0;
    wait_outs(2);
    repeat (10) @(posedge clk);
    #1;
    check_outs("s5", 2, '{0, 1, 0, 0, 0}, '{50, 60, 0, 0, 0});

    // Reset mid-computation drops the sample and its history update
    do_reset();
    send(0, 8);
    wait_outs(1);
    send(0, 40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("s6_no_output", log_dat.size(), 1);
    send(0, 8);
    wait_outs(2);
    check_outs("s6", 2, '{0, 0, 0, 0, 0}, '{8, 8, 0, 0, 0});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got t=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
